// File: rtl/cache_block_fill_ctrl_if.sv
// rtl/cache_block_fill_ctrl_if.sv - miss request, stall and memory port bundle for the block fill controller
interface cache_block_fill_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int WORDS  = 8
);
  localparam int IDX_W = $clog2(WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              victim_dirty;
  logic [ADDR_W-1:0] victim_address;
  logic              memory_data_valid;
  logic              fsm_busy;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [ADDR_W-1:0] memory_address;
  logic [IDX_W-1:0]  data_array_word;
  logic              write_data_array;
  logic              write_tag_array;

  modport master (
    input  miss_detected, miss_address, victim_dirty, victim_address, memory_data_valid,
    output fsm_busy, mem_read_en, mem_write_en, memory_address,
    output data_array_word, write_data_array, write_tag_array
  );

  modport slave (
    output miss_detected, miss_address, victim_dirty, victim_address, memory_data_valid,
    input  fsm_busy, mem_read_en, mem_write_en, memory_address,
    input  data_array_word, write_data_array, write_tag_array
  );
endinterface

// File: rtl/cache_block_fill_ctrl.sv
// rtl/cache_block_fill_ctrl.sv - dirty-victim writeback then pipelined block fill, optional critical word first
module cache_block_fill_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int WORDS      = 8,
  parameter int WORD_BYTES = 2,
  parameter int CWF        = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  cache_block_fill_ctrl_if.master bus
);
  localparam int IDX_W  = $clog2(WORDS);
  localparam int BYTE_W = $clog2(WORD_BYTES);
  localparam int OFF_W  = IDX_W + BYTE_W;
  localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'((1 << OFF_W) - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] miss_base, victim_base;
  logic [IDX_W-1:0]  start_idx, wb_cnt, rt_cnt;
  logic [IDX_W:0]    rq_cnt;
  logic [IDX_W-1:0]  start_sel, rd_idx;
  logic              rq_done;

  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base | (ADDR_W'(idx) << BYTE_W);
  endfunction

  generate
    if (CWF != 0) begin : g_cwf
      assign start_sel = bus.miss_address[OFF_W-1:BYTE_W];
    end else begin : g_linear
      assign start_sel = '0;
    end
  endgenerate

  // Requests saturate at WORDS; once done the address sticks at the last issued word.
  assign rq_done = rq_cnt[IDX_W];
  assign rd_idx  = start_idx + (rq_done ? LAST_IDX : rq_cnt[IDX_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      miss_base   <= '0;
      victim_base <= '0;
      start_idx   <= '0;
      wb_cnt      <= '0;
      rq_cnt      <= '0;
      rt_cnt      <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          wb_cnt <= '0;
          rq_cnt <= '0;
          rt_cnt <= '0;
          if (bus.miss_detected) begin
            miss_base   <= bus.miss_address & BASE_MASK;
            victim_base <= bus.victim_address & BASE_MASK;
            start_idx   <= start_sel;
          end
        end
        WRITEBACK: wb_cnt <= wb_cnt + IDX_W'(1);
        FILL: begin
          if (!rq_done) rq_cnt <= rq_cnt + (IDX_W + 1)'(1);
          if (bus.memory_data_valid) rt_cnt <= rt_cnt + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next           = state;
    bus.fsm_busy         = 1'b0;
    bus.mem_read_en      = 1'b0;
    bus.mem_write_en     = 1'b0;
    bus.memory_address   = bus.miss_address;
    bus.data_array_word  = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.miss_detected) state_next = bus.victim_dirty ? WRITEBACK : FILL;
      end
      WRITEBACK: begin
        bus.fsm_busy        = 1'b1;
        bus.mem_write_en    = 1'b1;
        bus.data_array_word = wb_cnt;
        bus.memory_address  = word_addr(victim_base, wb_cnt);
        if (wb_cnt == LAST_IDX) state_next = FILL;
      end
      FILL: begin
        bus.fsm_busy         = 1'b1;
        bus.mem_read_en      = !rq_done;
        bus.memory_address   = word_addr(miss_base, rd_idx);
        bus.data_array_word  = start_idx + rt_cnt;
        bus.write_data_array = bus.memory_data_valid;
        // Returns arrive in request order, so the last return closes the fill.
        if (bus.memory_data_valid && rt_cnt == LAST_IDX) begin
          bus.write_tag_array = 1'b1;
          state_next          = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_block_fill_ctrl.sv
// tb/tb_cache_block_fill_ctrl.sv - three controller configurations driven in lockstep against a cycle-arithmetic model
module tb_cache_block_fill_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        victim_dirty;
  logic [15:0] victim_address;
  logic        mem_valid;

  cache_block_fill_ctrl_if #(.ADDR_W(16), .WORDS(8)) bus0 ();
  cache_block_fill_ctrl_if #(.ADDR_W(16), .WORDS(8)) bus1 ();
  cache_block_fill_ctrl_if #(.ADDR_W(16), .WORDS(4)) bus2 ();

  cache_block_fill_ctrl #(.ADDR_W(16), .WORDS(8), .WORD_BYTES(2), .CWF(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  cache_block_fill_ctrl #(.ADDR_W(16), .WORDS(8), .WORD_BYTES(2), .CWF(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
  cache_block_fill_ctrl #(.ADDR_W(16), .WORDS(4), .WORD_BYTES(2), .CWF(1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  assign bus0.miss_detected = miss_detected;   assign bus1.miss_detected = miss_detected;   assign bus2.miss_detected = miss_detected;
  assign bus0.miss_address = miss_address;     assign bus1.miss_address = miss_address;     assign bus2.miss_address = miss_address;
  assign bus0.victim_dirty = victim_dirty;     assign bus1.victim_dirty = victim_dirty;     assign bus2.victim_dirty = victim_dirty;
  assign bus0.victim_address = victim_address; assign bus1.victim_address = victim_address; assign bus2.victim_address = victim_address;
  assign bus0.memory_data_valid = mem_valid;   assign bus1.memory_data_valid = mem_valid;   assign bus2.memory_data_valid = mem_valid;

  typedef struct {
    logic        busy, rd, wr, wda, wta;
    logic [15:0] addr;
    logic [31:0] word;
  } obs_t;

  int          n_assert = 0;
  int          n_fail = 0;
  int          w_of [3] = '{8, 8, 4};
  bit          cwf_of [3] = '{1'b0, 1'b1, 1'b1};
  logic [15:0] m0, va;
  bit          dirty;
  bit          vpat [0:127];
  bit          spur [0:127];
  logic [15:0] mad [0:127];
  int          rst_at;
  logic [15:0] addr_log [3][0:127];
  bit          rd_log [3][0:127];
  bit          wr_log [3][0:127];
  logic [31:0] word_log [3][0:127];
  int          wda_cnt [3];
  int          wta_cnt [3];
  int          tagc [3];

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
    end
  endtask

  function automatic int fill_start(input int w);
    return dirty ? w + 1 : 1;
  endfunction

  // Cycle holding the w-th return seen once the fill has started.
  function automatic int end_cycle(input int w);
    int cnt = 0;
    for (int c = fill_start(w); c < 128; c++) begin
      cnt += int'(vpat[c]);
      if (cnt == w) return c;
    end
    return 127;
  endfunction

  function automatic obs_t model(input int w, input bit cwf, input int c);
    obs_t r;
    int off = $clog2(w) + 1;
    int mb  = (int'(m0) >> off) << off;
    int vb  = (int'(va) >> off) << off;
    int s   = cwf ? (int'(m0) >> 1) % w : 0;
    int fs  = fill_start(w);
    int e   = end_cycle(w);
    int rt  = 0;
    int k;
    r.busy = 1'b0; r.rd = 1'b0; r.wr = 1'b0; r.wda = 1'b0; r.wta = 1'b0;
    r.addr = mad[c];
    r.word = 32'd0;
    if (c >= 1 && c <= e && c <= rst_at) begin
      r.busy = 1'b1;
      if (c < fs) begin
        r.wr   = 1'b1;
        r.word = 32'(c - 1);
        r.addr = 16'(vb + (c - 1) * 2);
      end else begin
        k      = c - fs;
        r.rd   = (k < w);
        r.addr = 16'(mb + ((s + ((k < w) ? k : w - 1)) % w) * 2);
        for (int i = fs; i < c; i++) rt += int'(vpat[i]);
        r.word = 32'((s + rt) % w);
        r.wda  = vpat[c];
        r.wta  = vpat[c] && (rt == w - 1);
      end
    end
    return r;
  endfunction

  function automatic obs_t observe(input int d);
    obs_t o;
    case (d)
      0: begin
        o.busy = bus0.fsm_busy; o.rd = bus0.mem_read_en; o.wr = bus0.mem_write_en;
        o.wda = bus0.write_data_array; o.wta = bus0.write_tag_array;
        o.addr = bus0.memory_address; o.word = 32'(bus0.data_array_word);
      end
      1: begin
        o.busy = bus1.fsm_busy; o.rd = bus1.mem_read_en; o.wr = bus1.mem_write_en;
        o.wda = bus1.write_data_array; o.wta = bus1.write_tag_array;
        o.addr = bus1.memory_address; o.word = 32'(bus1.data_array_word);
      end
      default: begin
        o.busy = bus2.fsm_busy; o.rd = bus2.mem_read_en; o.wr = bus2.mem_write_en;
        o.wda = bus2.write_data_array; o.wta = bus2.write_tag_array;
        o.addr = bus2.memory_address; o.word = 32'(bus2.data_array_word);
      end
    endcase
    return o;
  endfunction

  task automatic prep(input logic [15:0] ma, input bit d, input logic [15:0] v);
    m0 = ma; dirty = d; va = v; rst_at = 1000;
    for (int c = 0; c < 128; c++) begin
      vpat[c] = 1'b0;
      spur[c] = 1'b0;
      mad[c]  = 16'($urandom);
    end
    mad[0] = ma;
  endtask

  // Returns timed for the 8-word configuration with a fixed read latency.
  task automatic latency(input int l);
    for (int k = 0; k < 8; k++) vpat[fill_start(8) + k + l] = 1'b1;
  endtask

  task automatic run_txn(input string name);
    int   ncyc = 0;
    int   endc;
    obs_t o, x;
    for (int d = 0; d < 3; d++) begin
      endc = end_cycle(w_of[d]);
      if (rst_at < endc) endc = rst_at;
      if (endc + 2 > ncyc) ncyc = endc + 2;
      wda_cnt[d] = 0; wta_cnt[d] = 0; tagc[d] = -1;
    end
    if (ncyc > 127) ncyc = 127;
    victim_dirty   = dirty;
    victim_address = va;
    for (int c = 0; c <= ncyc; c++) begin
      miss_detected = (c == 0) || spur[c];
      miss_address  = mad[c];
      mem_valid     = vpat[c];
      rst           = (c == rst_at);
      #2;
      for (int d = 0; d < 3; d++) begin
        o = observe(d);
        x = model(w_of[d], cwf_of[d], c);
        chk($sformatf("%s_d%0d_c%0d_busy", name, d, c), 32'(o.busy), 32'(x.busy));
        chk($sformatf("%s_d%0d_c%0d_rd", name, d, c), 32'(o.rd), 32'(x.rd));
        chk($sformatf("%s_d%0d_c%0d_wr", name, d, c), 32'(o.wr), 32'(x.wr));
        chk($sformatf("%s_d%0d_c%0d_addr", name, d, c), 32'(o.addr), 32'(x.addr));
        chk($sformatf("%s_d%0d_c%0d_word", name, d, c), o.word, x.word);
        chk($sformatf("%s_d%0d_c%0d_wda", name, d, c), 32'(o.wda), 32'(x.wda));
        chk($sformatf("%s_d%0d_c%0d_wta", name, d, c), 32'(o.wta), 32'(x.wta));
        addr_log[d][c] = o.addr; rd_log[d][c] = o.rd; wr_log[d][c] = o.wr; word_log[d][c] = o.word;
        if (o.wda === 1'b1) wda_cnt[d]++;
        if (o.wta === 1'b1) begin wta_cnt[d]++; tagc[d] = c; end
      end
      @(posedge clk); #1;
    end
    miss_detected = 1'b0; mem_valid = 1'b0; rst = 1'b0;
  endtask

  logic [15:0] cwf_order [8] = '{16'h1236, 16'h1238, 16'h123A, 16'h123C, 16'h123E, 16'h1230, 16'h1232, 16'h1234};
  logic [15:0] wrap_order [4] = '{16'hFFFE, 16'hFFF8, 16'hFFFA, 16'hFFFC};
  int          cwf_words [8] = '{3, 4, 5, 6, 7, 0, 1, 2};

  initial begin
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h4321;
    victim_dirty = 1'b0; victim_address = 16'h0; mem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      obs_t o;
      o = observe(d);
      chk($sformatf("reset_d%0d_busy", d), 32'(o.busy), 32'd0);
      chk($sformatf("reset_d%0d_rd_wr", d), 32'({o.rd, o.wr}), 32'd0);
      chk($sformatf("reset_d%0d_wda_wta", d), 32'({o.wda, o.wta}), 32'd0);
      chk($sformatf("reset_d%0d_word", d), o.word, 32'd0);
      chk($sformatf("reset_d%0d_addr", d), 32'(o.addr), 32'h4321);
    end
    rst = 1'b0;

    prep(16'h1236, 1'b0, 16'h0000); latency(2); run_txn("clean_l2");
    chk("clean_l2_tag_cycle", 32'(tagc[0]), 32'd10);
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("clean_l2_rd_addr_c%0d", c), 32'(addr_log[0][c]), 32'(16'h1230 + 16'(2 * (c - 1))));
      chk($sformatf("cwf_order_c%0d", c), 32'(addr_log[1][c]), 32'(cwf_order[c-1]));
      chk($sformatf("cwf_word_c%0d", c + 2), word_log[1][c+2], 32'(cwf_words[c-1]));
    end

    prep(16'h5A14, 1'b1, 16'hA23A); latency(2); vpat[5] = 1'b1; run_txn("dirty");
    for (int c = 1; c <= 8; c++) begin
      chk($sformatf("dirty_wr_c%0d", c), 32'({wr_log[0][c], addr_log[0][c]}), 32'({1'b1, 16'hA230 + 16'(2 * (c - 1))}));
    end
    chk("dirty_first_read", 32'({rd_log[0][8], rd_log[0][9]}), 32'b01);

    prep(16'h0F0A, 1'b0, 16'h0000);
    for (int k = 0; k < 8; k++) vpat[2 + 3 * k] = 1'b1;
    run_txn("gaps");
    chk("gaps_data_writes", 32'(wda_cnt[0]), 32'd8);
    chk("gaps_tag_pulses", 32'(wta_cnt[0]), 32'd1);
    chk("gaps_tag_cycle", 32'(tagc[0]), 32'd23);

    prep(16'h3456, 1'b0, 16'h0000); latency(1); spur[2] = 1'b1; spur[3] = 1'b1; rst_at = 5;
    run_txn("abort");
    chk("abort_tag_d0", 32'(wta_cnt[0]), 32'd0);
    chk("abort_tag_d1", 32'(wta_cnt[1]), 32'd0);

    prep(16'hFFFE, 1'b0, 16'h0000); latency(1); run_txn("wrap");
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("wrap_order_c%0d", c), 32'(addr_log[2][c]), 32'(wrap_order[c-1]));
    end

    for (int t = 0; t < 8; t++) begin
      prep(16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom));
      for (int c = 1; c < 128; c++) vpat[c] = (c >= 60) || ($urandom_range(0, 2) != 0);
      run_txn($sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
